// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: observes a VGA sync/colour stream, measures line/frame timing, tracks pixel position,
// counts lit pixels per frame and reports lock once the timing has been stable for LOCK_FRAMES frames.
module vga_rx_monitor #(
  parameter int HW            = 12,
  parameter int VW            = 11,
  parameter int CW            = 20,
  parameter int HS_ACTIVE_LOW = 1,
  parameter int VS_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          red,
  input  logic          green,
  input  logic          blue,
  input  logic          hsync,
  input  logic          vsync,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic [HW-1:0] line_period,
  output logic [HW-1:0] hsync_width,
  output logic [VW-1:0] frame_lines,
  output logic [VW-1:0] vsync_width,
  output logic [CW-1:0] frame_lit,
  output logic          frame_done,
  output logic          locked,
  output logic          timeout
);
  localparam int SW = $clog2(LOCK_FRAMES + 1);
  localparam logic [HW-1:0] HMAX = '1;
  localparam logic [VW-1:0] VMAX = '1;
  localparam logic [CW-1:0] CMAX = '1;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state, state_n;
  logic [4:0] s1, s2;
  logic s3_h, s3_v;
  logic hs, vs, h_lead, h_trail, v_lead, v_trail, lit;
  logic [HW-1:0] hcnt, hswcnt, new_period;
  logic [VW-1:0] vcnt, vswcnt, new_lines;
  logic [CW-1:0] litcnt, new_lit;
  logic [SW-1:0] stable_cnt, cnt_n, cnt_inc;
  logic line_mismatch, period_bad, stable, h_to, locked_n, done_n;
  // syncs are normalised to active-high before the synchroniser so reset means "inactive"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      s3_h <= 1'b0;
      s3_v <= 1'b0;
    end else begin
      s1   <= {red, green, blue, hsync ^ (HS_ACTIVE_LOW != 0), vsync ^ (VS_ACTIVE_LOW != 0)};
      s2   <= s1;
      s3_h <= s2[1];
      s3_v <= s2[0];
    end
  end
  assign hs         = s2[1];
  assign vs         = s2[0];
  assign h_lead     = hs & ~s3_h;
  assign h_trail    = ~hs & s3_h;
  assign v_lead     = vs & ~s3_v;
  assign v_trail    = ~vs & s3_v;
  assign lit        = |s2[4:2];
  assign new_period = (hcnt == HMAX) ? HMAX : hcnt + HW'(1);
  assign new_lines  = (vcnt == VMAX) ? VMAX : vcnt + VW'(h_lead);
  assign new_lit    = (litcnt == CMAX) ? CMAX : litcnt + CW'(lit);
  assign h_to       = (hcnt == HMAX) & ~h_lead;
  assign period_bad = h_lead & (new_period != line_period);
  assign stable     = ~line_mismatch & ~period_bad & (new_lines == frame_lines);
  assign cnt_inc    = stable_cnt + SW'(1);
  assign pixel_x    = hcnt;
  assign pixel_y    = vcnt;
  always_comb begin
    state_n  = state;
    cnt_n    = stable_cnt;
    locked_n = locked;
    done_n   = 1'b0;
    if (h_to) begin
      state_n  = SEARCH;
      cnt_n    = '0;
      locked_n = 1'b0;
    end else if (v_lead) begin
      case (state)
        SEARCH: begin
          state_n = MEASURE;
          cnt_n   = '0;
        end
        MEASURE: begin
          done_n = 1'b1;
          cnt_n  = stable ? cnt_inc : '0;
          if (stable && cnt_inc == SW'(LOCK_FRAMES)) begin
            state_n  = LOCKED;
            locked_n = 1'b1;
          end
        end
        LOCKED: begin
          done_n = 1'b1;
          if (!stable) begin
            state_n  = MEASURE;
            cnt_n    = '0;
            locked_n = 1'b0;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt          <= '0;
      hswcnt        <= '0;
      vcnt          <= '0;
      vswcnt        <= '0;
      litcnt        <= '0;
      line_mismatch <= 1'b0;
      line_period   <= '0;
      hsync_width   <= '0;
      frame_lines   <= '0;
      vsync_width   <= '0;
      frame_lit     <= '0;
      timeout       <= 1'b0;
      state         <= SEARCH;
      stable_cnt    <= '0;
      locked        <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      hcnt          <= h_lead ? '0 : (hcnt == HMAX) ? hcnt : hcnt + HW'(1);
      line_period   <= h_lead ? new_period : line_period;
      hswcnt        <= h_lead ? HW'(1) : (hs && hswcnt != HMAX) ? hswcnt + HW'(1) : hswcnt;
      hsync_width   <= h_trail ? hswcnt : hsync_width;
      timeout       <= h_lead ? 1'b0 : (hcnt == HMAX) ? 1'b1 : timeout;
      line_mismatch <= v_lead ? 1'b0 : period_bad ? 1'b1 : line_mismatch;
      vcnt          <= v_lead ? '0 : new_lines;
      frame_lines   <= v_lead ? new_lines : frame_lines;
      vswcnt        <= v_lead ? VW'(h_lead) : (h_lead && vs && vswcnt != VMAX) ? vswcnt + VW'(1) : vswcnt;
      vsync_width   <= v_trail ? vswcnt : vsync_width;
      litcnt        <= v_lead ? '0 : new_lit;
      frame_lit     <= v_lead ? new_lit : frame_lit;
      state         <= state_n;
      stable_cnt    <= cnt_n;
      locked        <= locked_n;
      frame_done    <= done_n;
    end
  end
endmodule
